monopix2_ro_fsm: RTL and testbench

Chip-side readout sequencer for LF-Monopix2 token/freeze/read readout, running in the RX clock domain, directly upstream of the data-RX FIFO and arbiter.
- On a synchronised TokOut it asserts Freeze, then pulses Read once per hit, shifts in the DataOut bit stream and emits one 32-bit word per hit.
- It counts frames and drops words when the downstream FIFO is full, reporting each drop in a counter.

---
 rtl/monopix2_ro_fsm.sv | 136 +++++++++++++
 tb/tb_monopix2_ro_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/monopix2_ro_fsm.sv
// monopix2_ro_fsm: LF-Monopix2 token/freeze/read readout sequencer; define MONOPIX2_RO_FRAME_TAG_EN for per-frame header words
module monopix2_ro_fsm #(
  parameter int DATA_BITS    = 29,
  parameter int FREEZE_SETUP = 3,
  parameter int READ_LEN     = 2,
  parameter int FREEZE_HOLD  = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        CONF_EN,
  input  logic        TOKEN,
  input  logic        DATA_IN,
  input  logic        FIFO_FULL,
  output logic        FREEZE,
  output logic        READ,
  output logic [31:0] WORD_OUT,
  output logic        WORD_VALID,
  output logic [7:0]  LOST_CNT,
  output logic        BUSY
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
`ifdef MONOPIX2_RO_FRAME_TAG_EN
  localparam logic [2:0] S_TAG   = 3'd6;
  localparam logic [2:0] S_POST_SETUP = S_TAG;
`else
  localparam logic [2:0] S_POST_SETUP = S_READ;
`endif

  logic [1:0]           rst_sync_q;
  logic                 rst_ni;
  logic                 tok_meta_q, tok_s_q;
  logic [2:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [15:0]          frame_q, frame_d;
  logic [31:0]          word_q, word_d, word_c;
  logic                 valid_q, valid_d;
  logic [7:0]           lost_q, lost_d;
  logic                 freeze_q, freeze_d;
  logic                 read_q, read_d;
  logic                 emit;

  // reset asserts asynchronously and releases two CLK edges after nRST rises
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};

  assign rst_ni = rst_sync_q[1];

  // two-flop synchroniser for the asynchronous chip TokOut
  always_ff @(posedge CLK or negedge rst_ni)
    if (!rst_ni) begin
      tok_meta_q <= 1'b0;
      tok_s_q    <= 1'b0;
    end else begin
      tok_meta_q <= TOKEN;
      tok_s_q    <= tok_meta_q;
    end

  // sequencing: next state, dwell counter, shift register and word/drop bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    sr_d    = sr_q;
    frame_d = frame_q;
    emit    = 1'b0;
    word_c  = 32'(sr_q);
    case (state_q)
      S_IDLE: if (CONF_EN && tok_s_q) begin
        state_d = S_SETUP;
        frame_d = frame_q + 16'd1;
      end
      S_SETUP: if (cnt_q == 8'(FREEZE_SETUP - 1)) state_d = S_POST_SETUP;
`ifdef MONOPIX2_RO_FRAME_TAG_EN
      S_TAG: begin
        emit    = 1'b1;
        word_c  = {1'b1, 15'b0, frame_q};
        state_d = S_READ;
      end
`endif
      S_READ: if (cnt_q == 8'(READ_LEN - 1)) state_d = S_SHIFT;
      S_SHIFT: begin
        sr_d = {sr_q[DATA_BITS-2:0], DATA_IN};
        if (cnt_q == 8'(DATA_BITS - 1)) state_d = S_PUSH;
      end
      S_PUSH: begin
        emit    = 1'b1;
        state_d = (tok_s_q && CONF_EN) ? S_READ : S_HOLD;
      end
      S_HOLD: if (cnt_q == 8'(FREEZE_HOLD - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = 8'd0;
    valid_d  = emit && !FIFO_FULL;
    word_d   = valid_d ? word_c : word_q;
    lost_d   = (emit && FIFO_FULL && lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;
    freeze_d = state_d != S_IDLE;
    read_d   = state_d == S_READ;
  end

  // state and registered outputs
  always_ff @(posedge CLK or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      sr_q     <= '0;
      frame_q  <= 16'd0;
      word_q   <= 32'd0;
      valid_q  <= 1'b0;
      lost_q   <= 8'd0;
      freeze_q <= 1'b0;
      read_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      frame_q  <= frame_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
      freeze_q <= freeze_d;
      read_q   <= read_d;
    end

  assign FREEZE     = freeze_q;
  assign READ       = read_q;
  assign WORD_OUT   = word_q;
  assign WORD_VALID = valid_q;
  assign LOST_CNT   = lost_q;
  assign BUSY       = state_q != S_IDLE;
endmodule

// File: tb/tb_monopix2_ro_fsm.sv
// tb_monopix2_ro_fsm: scoreboard bench with a behavioural chip model for monopix2_ro_fsm
module tb_monopix2_ro_fsm;
  localparam int DB = 29, FS = 3, RL = 2, FH = 3;
`ifdef MONOPIX2_RO_FRAME_TAG_EN
  localparam int TAGX = 1;
`else
  localparam int TAGX = 0;
`endif

  logic        CLK = 1'b0, nRST = 1'b1, CONF_EN = 1'b0, TOKEN = 1'b0, DATA_IN = 1'b0, FIFO_FULL = 1'b0;
  logic        FREEZE, READ, WORD_VALID, BUSY;
  logic [31:0] WORD_OUT;
  logic [7:0]  LOST_CNT;

  int          total = 0, bad = 0, cyc = 0, lost_m = 0, frames_m = 0, reads = 0;
  logic [31:0] exp_q[$];
  logic [28:0] hits[$];
  logic [28:0] cur = '0;
  int          idx = -1;
  logic        rp = 1'b0, fp = 1'b0;

  monopix2_ro_fsm #(.DATA_BITS(DB), .FREEZE_SETUP(FS), .READ_LEN(RL), .FREEZE_HOLD(FH)) dut (
    .CLK(CLK), .nRST(nRST), .CONF_EN(CONF_EN), .TOKEN(TOKEN), .DATA_IN(DATA_IN),
    .FIFO_FULL(FIFO_FULL), .FREEZE(FREEZE), .READ(READ), .WORD_OUT(WORD_OUT),
    .WORD_VALID(WORD_VALID), .LOST_CNT(LOST_CNT), .BUSY(BUSY)
  );

  initial forever #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    if (FIFO_FULL) lost_m = (lost_m < 255) ? lost_m + 1 : 255;
    else exp_q.push_back(w);
  endtask

  task automatic add_hit(input logic [28:0] w);
    hits.push_back(w);
    TOKEN = 1'b1;
  endtask

  function automatic logic sig(input int w);
    return (w == 0) ? FREEZE : (w == 1) ? READ : (w == 2) ? BUSY : (WORD_VALID && !WORD_OUT[31]);
  endfunction

  task automatic wait_sig(input string nm, input int w, input logic v, input int budget, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (sig(w) !== v && n < budget);
    if (sig(w) !== v) begin
      total++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles, want %0b", nm, n, v);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    repeat (5) @(negedge CLK);
    wait_sig("idle", 2, 1'b0, budget, n);
  endtask

  // chip model: pops a hit per Read pulse, shifts it out MSB first after Read falls
  initial forever begin
    @(negedge CLK);
    if (FREEZE && !fp) begin
      frames_m = (frames_m + 1) & 32'hFFFF;
      if (TAGX != 0) expect_word({16'h8000, 16'(frames_m)});
    end
    if (READ && !rp) begin
      reads++;
      if (hits.size() == 0) begin
        total++;
        bad++;
        $display("FAIL read_without_hit: got READ=1 want no READ");
      end else begin
        cur = hits.pop_front();
        TOKEN = hits.size() != 0;
        expect_word({3'b000, cur});
      end
    end
    if (!READ && rp) idx = DB - 1;
    if (idx >= 0) begin
      DATA_IN = cur[idx];
      idx--;
    end
    rp = READ;
    fp = FREEZE;
  end

  // scoreboard monitor
  initial forever begin
    @(negedge CLK);
    if (WORD_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %08h want none", WORD_OUT);
      end else chk("word", WORD_OUT, exp_q.pop_front());
    end
  end

  initial begin
    int n, r0, fr;
    int rt[$];
    logic lr, lf;
    #1 nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_freeze", FREEZE, 0);
    chk("rst_read", READ, 0);
    chk("rst_word", WORD_OUT, 0);
    chk("rst_valid", WORD_VALID, 0);
    chk("rst_lost", LOST_CNT, 0);
    chk("rst_busy", BUSY, 0);
    nRST = 1'b1;
    repeat (4) @(negedge CLK);
    chk("post_rst_busy", BUSY, 0);
    CONF_EN = 1'b1;
    add_hit(29'h1ABCDEF5);
    wait_sig("tok_to_freeze", 0, 1'b1, 20, n);
    chk("tok_to_freeze", n, 3);
    wait_sig("freeze_to_read", 1, 1'b1, 20, n);
    chk("freeze_to_read", n, FS + TAGX);
    wait_sig("read_len", 1, 1'b0, 20, n);
    chk("read_len", n, RL);
    wait_sig("read_to_word", 3, 1'b1, 60, n);
    chk("read_to_word", n, DB + 1);
    wait_sig("word_to_freeze_low", 0, 1'b0, 20, n);
    chk("word_to_freeze_low", n, FH);
    repeat (5) @(negedge CLK);
    chk("word_hold", WORD_OUT, 32'h1ABCDEF5);
    chk("valid_single", WORD_VALID, 0);
    wait_idle(100);

    add_hit(29'h0123_4567);
    add_hit(29'h1555_AAAA);
    add_hit(29'h0F0F_F0F0);
    fr = 0;
    lr = 1'b0;
    lf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (READ && !lr) rt.push_back(cyc);
      if (FREEZE && !lf) fr++;
      lr = READ;
      lf = FREEZE;
      if (rt.size() == 3 && !FREEZE) break;
    end
    chk("three_reads", rt.size(), 3);
    if (rt.size() == 3) begin
      chk("read_spacing_1", rt[1] - rt[0], RL + DB + 1);
      chk("read_spacing_2", rt[2] - rt[1], RL + DB + 1);
    end
    chk("one_freeze_window", fr, 1);
    wait_idle(100);

    for (int f = 0; f < 6; f++) begin
      FIFO_FULL = $urandom_range(0, 3) == 0;
      n = $urandom_range(1, 4);
      for (int h = 0; h < n; h++) add_hit(29'($urandom));
      wait_idle(400);
      FIFO_FULL = 1'b0;
    end
    chk("lost_random", LOST_CNT, lost_m);

    r0 = reads;
    add_hit(29'h1234_5678);
    add_hit(29'h0765_4321);
    add_hit(29'h1FFF_0000);
    wait_sig("conf_drop_read", 1, 1'b1, 40, n);
    CONF_EN = 1'b0;
    wait_sig("conf_drop_idle", 2, 1'b0, 100, n);
    repeat (40) @(negedge CLK);
    chk("conf_drop_reads", reads - r0, 1);
    chk("conf_drop_busy", BUSY, 0);
    hits.delete();
    TOKEN = 1'b0;
    repeat (5) @(negedge CLK);
    CONF_EN = 1'b1;

    add_hit(29'h0AAA_5555);
    add_hit(29'h1333_CCCC);
    wait_sig("rst_mid_read", 1, 1'b1, 40, n);
    wait_sig("rst_mid_shift", 1, 1'b0, 20, n);
    repeat (10) @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("rst_mid_freeze", FREEZE, 0);
    chk("rst_mid_read", READ, 0);
    chk("rst_mid_busy", BUSY, 0);
    exp_q.delete();
    hits.delete();
    TOKEN = 1'b0;
    lost_m = 0;
    frames_m = 0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);
    chk("rst_mid_lost", LOST_CNT, 0);
    chk("rst_mid_busy_after", BUSY, 0);
    add_hit(29'h0F0F_0F0F);
    wait_idle(100);

    FIFO_FULL = 1'b1;
    for (int h = 0; h < 300; h++) add_hit(29'($urandom));
    wait_idle(12000);
    FIFO_FULL = 1'b0;
    chk("lost_saturated", LOST_CNT, 255);
    chk("lost_model", LOST_CNT, lost_m);
    repeat (5) @(negedge CLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
